// File: rtl/serial_frame_receiver.sv
// Receive-side deframer for the acquisition serial readout link: rebuilds the
// timestamp and bank-addressed memory words from the MSB-first bit stream.
module serial_frame_receiver #(
    parameter int unsigned TS_W      = 30,
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned MAX_WORDS = 200,
    parameter int unsigned IDX_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_frame,
    input  logic              rx_valid,
    input  logic              rx_sel,
    input  logic              rx_bit,
    output logic [TS_W-1:0]   ts_out,
    output logic              ts_valid,
    output logic [WORD_W-1:0] word_out,
    output logic [IDX_W-1:0]  word_idx,
    output logic              word_valid,
    output logic              bank_done,
    output logic              frame_done,
    output logic [IDX_W+1:0]  word_count,
    output logic              err_ts,
    output logic              err_partial,
    output logic              busy
);
    localparam int unsigned SH_W  = (TS_W > WORD_W) ? TS_W : WORD_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);
    localparam int unsigned WC_W  = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, TS, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic [SH_W-1:0]   shreg_q, shreg_d, shifted;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic              armed_q, armed_d;
    logic              ts_bit, data_bit, last_idx;

    logic [TS_W-1:0]   ts_out_d;
    logic [WORD_W-1:0] word_out_d;
    logic [IDX_W-1:0]  word_idx_d;
    logic [WC_W-1:0]   word_count_d;
    logic              ts_valid_d, word_valid_d, bank_done_d, frame_done_d;
    logic              err_ts_d, err_partial_d, busy_d;

    assign shifted  = {shreg_q[SH_W-2:0], rx_bit};
    assign last_idx = (idx_q == IDX_W'(MAX_WORDS - 1));

    // Next-state and registered-output computation
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bitcnt_d      = bitcnt_q;
        idx_d         = idx_q;
        wcnt_d        = wcnt_q;
        // A frame interrupted by reset is skipped until the link goes quiet
        armed_d       = armed_q | ~rx_frame;
        ts_bit        = 1'b0;
        data_bit      = 1'b0;
        ts_out_d      = ts_out;
        ts_valid_d    = 1'b0;
        word_out_d    = word_out;
        word_idx_d    = word_idx;
        word_valid_d  = 1'b0;
        bank_done_d   = 1'b0;
        frame_done_d  = 1'b0;
        word_count_d  = word_count;
        err_ts_d      = err_ts;
        err_partial_d = err_partial;

        unique case (state_q)
            IDLE: begin
                if (armed_q && rx_frame && rx_valid) begin
                    bitcnt_d = '0;
                    if (!rx_sel) begin
                        state_d = TS;
                        ts_bit  = 1'b1;
                    end else begin
                        err_ts_d = 1'b1;
                        state_d  = DATA;
                        data_bit = 1'b1;
                    end
                end
            end
            TS: begin
                if (!rx_frame) begin
                    // A truncated timestamp is a timestamp error, not a partial word
                    err_ts_d = 1'b1;
                    bitcnt_d = '0;
                    state_d  = DONE;
                end else if (rx_valid && !rx_sel) begin
                    ts_bit = 1'b1;
                end else if (rx_valid && rx_sel) begin
                    err_ts_d = 1'b1;
                    bitcnt_d = '0;
                    state_d  = DATA;
                    data_bit = 1'b1;
                end
            end
            DATA: begin
                data_bit = rx_valid & rx_sel;
                if (!rx_frame) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done_d = 1'b1;
                if (bitcnt_q != '0) begin
                    err_partial_d = 1'b1;
                end
                idx_d    = '0;
                bitcnt_d = '0;
                wcnt_d   = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (ts_bit) begin
            shreg_d = shifted;
            if (bitcnt_d == CNT_W'(TS_W - 1)) begin
                ts_out_d   = TS_W'(shifted);
                ts_valid_d = 1'b1;
                bitcnt_d   = '0;
                state_d    = DATA;
            end else begin
                bitcnt_d = bitcnt_d + CNT_W'(1);
            end
        end

        if (data_bit) begin
            shreg_d = shifted;
            if (bitcnt_d == CNT_W'(WORD_W - 1)) begin
                word_out_d   = WORD_W'(shifted);
                word_idx_d   = idx_q;
                word_valid_d = 1'b1;
                bank_done_d  = last_idx;
                idx_d        = last_idx ? '0 : idx_q + IDX_W'(1);
                wcnt_d       = wcnt_q + WC_W'(1);
                word_count_d = wcnt_q + WC_W'(1);
                bitcnt_d     = '0;
            end else begin
                bitcnt_d = bitcnt_d + CNT_W'(1);
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            armed_q     <= 1'b0;
            ts_out      <= '0;
            ts_valid    <= 1'b0;
            word_out    <= '0;
            word_idx    <= '0;
            word_valid  <= 1'b0;
            bank_done   <= 1'b0;
            frame_done  <= 1'b0;
            word_count  <= '0;
            err_ts      <= 1'b0;
            err_partial <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            armed_q     <= armed_d;
            ts_out      <= ts_out_d;
            ts_valid    <= ts_valid_d;
            word_out    <= word_out_d;
            word_idx    <= word_idx_d;
            word_valid  <= word_valid_d;
            bank_done   <= bank_done_d;
            frame_done  <= frame_done_d;
            word_count  <= word_count_d;
            err_ts      <= err_ts_d;
            err_partial <= err_partial_d;
            busy        <= busy_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench for serial_frame_receiver: a frame-level model queues the
// expected timestamps, words and frame ends; a monitor checks every DUT pulse.
module tb_serial_frame_receiver;
    localparam int unsigned TS_W      = 30;
    localparam int unsigned WORD_W    = 16;
    localparam int unsigned MAX_WORDS = 200;
    localparam int unsigned IDX_W     = 8;
    localparam int unsigned WC_W      = IDX_W + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              rx_frame = 1'b0, rx_valid = 1'b0, rx_sel = 1'b0, rx_bit = 1'b0;
    logic [TS_W-1:0]   ts_out;
    logic              ts_valid;
    logic [WORD_W-1:0] word_out;
    logic [IDX_W-1:0]  word_idx;
    logic              word_valid, bank_done, frame_done;
    logic [WC_W-1:0]   word_count;
    logic              err_ts, err_partial, busy;

    serial_frame_receiver dut (
        .clk(clk), .reset(reset), .rx_frame(rx_frame), .rx_valid(rx_valid),
        .rx_sel(rx_sel), .rx_bit(rx_bit), .ts_out(ts_out), .ts_valid(ts_valid),
        .word_out(word_out), .word_idx(word_idx), .word_valid(word_valid),
        .bank_done(bank_done), .frame_done(frame_done), .word_count(word_count),
        .err_ts(err_ts), .err_partial(err_partial), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WORD_W-1:0] val;
        logic [IDX_W-1:0]  idx;
        logic              bank;
    } wexp_t;

    logic [TS_W-1:0]   ts_q[$];
    wexp_t             w_q[$];
    logic [WC_W-1:0]   fd_q[$];
    logic [WORD_W-1:0] tx_words[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_err_ts = 1'b0;
    logic exp_err_partial = 1'b0;
    int   last_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse must match the head of its queue
    logic [TS_W-1:0] m_ts;
    wexp_t           m_w;
    logic [WC_W-1:0] m_fd;
    always @(negedge clk) begin
        if (reset) begin
            if (ts_valid) begin
                if (ts_q.size() == 0) check("ts_valid_unexpected", 1, 0);
                else begin
                    m_ts = ts_q.pop_front();
                    check("ts_out", 64'(ts_out), 64'(m_ts));
                end
            end
            if (word_valid) begin
                if (w_q.size() == 0) check("word_valid_unexpected", 1, 0);
                else begin
                    m_w = w_q.pop_front();
                    check("word_out", 64'(word_out), 64'(m_w.val));
                    check("word_idx", 64'(word_idx), 64'(m_w.idx));
                    check("bank_done", 64'(bank_done), 64'(m_w.bank));
                end
            end else if (bank_done) begin
                check("bank_done_without_word", 1, 0);
            end
            if (frame_done) begin
                if (fd_q.size() == 0) check("frame_done_unexpected", 1, 0);
                else begin
                    m_fd = fd_q.pop_front();
                    check("word_count", 64'(word_count), 64'(m_fd));
                end
            end
        end
    end

    task automatic send_bit(input logic sel, input logic b, input bit gaps, input bit drop);
        if (gaps) begin
            repeat ($urandom_range(1, 3)) begin
                @(posedge clk); #1;
                rx_valid = 1'b0; rx_sel = sel; rx_bit = 1'($urandom);
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_sel = sel; rx_bit = b;
        if (drop) rx_frame = 1'b0;
    endtask

    // Model the frame from its contents, then drive it on the link
    task automatic send_frame(input logic [TS_W-1:0] ts, input int n_ts, input int extra,
                              input bit gaps, input bit simul);
        int    nw;
        wexp_t e;
        bit    last;
        nw = tx_words.size();
        if (n_ts == TS_W) ts_q.push_back(ts);
        else exp_err_ts = 1'b1;
        for (int i = 0; i < nw; i++) begin
            e.val  = tx_words[i];
            e.idx  = IDX_W'(i % MAX_WORDS);
            e.bank = ((i % MAX_WORDS) == MAX_WORDS - 1);
            w_q.push_back(e);
        end
        if (extra != 0) exp_err_partial = 1'b1;
        if (nw > 0) last_count = nw;
        fd_q.push_back(WC_W'(last_count));

        rx_frame = 1'b1;
        for (int k = 0; k < n_ts; k++) send_bit(1'b0, ts[TS_W-1-k], gaps, 1'b0);
        for (int i = 0; i < nw; i++) begin
            for (int b = 0; b < WORD_W; b++) begin
                last = (i == nw - 1) && (b == WORD_W - 1) && (extra == 0);
                send_bit(1'b1, tx_words[i][WORD_W-1-b], gaps, last && simul);
            end
        end
        for (int x = 0; x < extra; x++) send_bit(1'b1, 1'($urandom), gaps, 1'b0);
        @(posedge clk); #1;
        rx_frame = 1'b0; rx_valid = 1'b0; rx_sel = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((ts_q.size() + w_q.size() + fd_q.size()) != 0 && t < 300) begin
            @(posedge clk); t++;
        end
        repeat (2) @(negedge clk);
        check({tag, "_pending_expectations"}, 64'(ts_q.size() + w_q.size() + fd_q.size()), 0);
        check({tag, "_err_ts"}, 64'(err_ts), 64'(exp_err_ts));
        check({tag, "_err_partial"}, 64'(err_partial), 64'(exp_err_partial));
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    task automatic load_clean();
        tx_words.delete();
        tx_words.push_back(16'h1234);
        tx_words.push_back(16'hBEEF);
        tx_words.push_back(16'h0001);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ts_out"}, 64'(ts_out), 0);
        check({tag, "_word_out"}, 64'(word_out), 0);
        check({tag, "_word_idx"}, 64'(word_idx), 0);
        check({tag, "_word_count"}, 64'(word_count), 0);
        check({tag, "_pulses"}, 64'({ts_valid, word_valid, bank_done, frame_done}), 0);
        check({tag, "_errors"}, 64'({err_ts, err_partial}), 0);
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    initial begin
        int n_ts, nw, extra;
        logic [TS_W-1:0] ts;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk); #1;

        load_clean();
        send_frame(30'h2AAAAAAA, TS_W, 0, 1'b0, 1'b0);
        drain("clean");

        tx_words.delete();
        for (int i = 0; i < 250; i++) tx_words.push_back(WORD_W'(i));
        send_frame(30'(($urandom)), TS_W, 0, 1'b0, 1'b0);
        drain("full_bank");

        load_clean();
        send_frame(30'h2AAAAAAA, TS_W, 0, 1'b1, 1'b0);
        drain("gapped");

        load_clean();
        send_frame(30'h3FFFFFFF, 20, 0, 1'b0, 1'b0);
        drain("short_ts");

        tx_words.delete();
        tx_words.push_back(16'hA5A5);
        tx_words.push_back(16'h5A5A);
        send_frame(30'h0123456, TS_W, 7, 1'b0, 1'b0);
        drain("partial");

        // Reset in the middle of the data field, then let the frame run on
        ts = 30'h1555AAAA;
        ts_q.push_back(ts);
        rx_frame = 1'b1;
        for (int k = 0; k < TS_W; k++) send_bit(1'b0, ts[TS_W-1-k], 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) send_bit(1'b1, 1'($urandom), 1'b0, 1'b0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(posedge clk); #1 reset = 1'b1;
        exp_err_ts = 1'b0; exp_err_partial = 1'b0; last_count = 0;
        for (int k = 0; k < 40; k++) send_bit(1'b1, 1'($urandom), 1'b0, 1'b0);
        @(negedge clk);
        check("post_reset_ignored_busy", 64'(busy), 0);
        @(posedge clk); #1 rx_frame = 1'b0; rx_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("post_reset_ts_queue", 64'(ts_q.size()), 0);
        load_clean();
        send_frame(30'h2AAAAAAA, TS_W, 0, 1'b0, 1'b1);
        drain("after_reset");

        for (int f = 0; f < 10; f++) begin
            n_ts  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TS_W - 1)) : TS_W;
            nw    = $urandom_range(0, 5);
            if (n_ts == 0 && nw == 0) nw = 1;
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WORD_W - 1)) : 0;
            tx_words.delete();
            for (int i = 0; i < nw; i++) tx_words.push_back(WORD_W'($urandom));
            send_frame(TS_W'($urandom), n_ts, extra, 1'($urandom),
                       (nw > 0) && (extra == 0) && 1'($urandom));
            drain("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_receiver.md
Name: serial_frame_receiver

Overview:
- Receive-side deframer for the acquisition serial readout link.
- Consumes the bit stream produced by the readout FSM: a timestamp (RTC) field, then channel-memory words.
- Rebuilds parallel timestamp and data words, tags each word with its bank address, and flags framing errors.
- Sits on the bench/host-side FPGA and feeds a capture FIFO.

Parameters:
TS_W, 30, timestamp field width in bits (RTC).
WORD_W, 16, memory data word width in bits.
MAX_WORDS, 200, words per full bank; word index wraps here.
IDX_W, 8, width of the word index (must hold MAX_WORDS-1).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
rx_frame  input  1  frame envelope (transmitter sending_data); high while a frame is on the link.
rx_valid  input  1  bit strobe (transmitter serial_readout); rx_bit sampled only when high.
rx_sel  input  1  field select (transmitter selection_bit); 0 = timestamp field, 1 = memory field.
rx_bit  input  1  serial data bit, MSB first.
ts_out  output  TS_W  last captured timestamp.
ts_valid  output  1  one-cycle pulse, ts_out updated.
word_out  output  WORD_W  last captured data word.
word_idx  output  IDX_W  bank address of word_out (0..MAX_WORDS-1).
word_valid  output  1  one-cycle pulse, word_out/word_idx updated.
bank_done  output  1  one-cycle pulse with the word_valid of index MAX_WORDS-1.
frame_done  output  1  one-cycle pulse at end of frame.
word_count  output  IDX_W+2  total words in the finished frame; valid with frame_done.
err_ts  output  1  sticky: timestamp field short or truncated.
err_partial  output  1  sticky: frame ended mid-word.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, shift registers and counters 0. Sticky errors clear only on reset.
- Shift rule: on each sampled bit, shreg <= {shreg, rx_bit}. The first bit received is the MSB.
- States: IDLE, TS, DATA, DONE.
- IDLE:
  - rx_frame=1, rx_valid=1, rx_sel=0 -> TS; this bit is timestamp bit 1, and bitcnt=1.
  - rx_frame=1, rx_valid=1, rx_sel=1 -> err_ts=1, enter DATA; this bit is data bit 1.
  - Otherwise stay in IDLE.
- TS:
  - Sample only while rx_valid=1 and rx_sel=0; rx_valid=0 holds all state.
  - When bitcnt reaches TS_W: ts_out <= shreg and ts_valid pulses on the next clock (latency 1 after last bit). Then bitcnt=0, go to DATA.
  - Further rx_sel=0 bits after TS_W are ignored.
  - rx_sel=1 with bitcnt<TS_W -> err_ts=1, ts_out unchanged, no ts_valid, bitcnt=0. Go to DATA; the current bit is data bit 1.
  - rx_frame=0 with bitcnt<TS_W -> err_ts=1, go to DONE.
- DATA:
  - Sample while rx_valid=1 and rx_sel=1. Bits with rx_sel=0 are ignored; they are load/idle cycles.
  - Every WORD_W bits: word_out <= shreg, word_idx <= idx, word_valid pulses (latency 1).
  - On the same cycle: idx increments, word_count increments, bitcnt resets.
  - idx = MAX_WORDS-1 -> bank_done pulses with that word, and idx wraps to 0.
  - rx_frame falling -> DONE.
- DONE (1 cycle):
  - frame_done pulses and word_count is presented.
  - bitcnt!=0 -> err_partial=1; the partial word is discarded.
  - Clear idx and bitcnt, go to IDLE. word_count holds until the next frame's first word, then restarts from 1.
- Simultaneous events: a completing bit and rx_frame falling on the same cycle -> the word is emitted first (word_valid). frame_done follows one cycle later, with word_count including that word.
- Back-to-back frames: rx_frame re-rising the cycle after DONE is accepted normally.
- Reset mid-frame: immediate return to IDLE with no pulses. After reset deasserts, the remainder of the in-progress frame is ignored until rx_frame is seen low.
- The receiver never back-pressures the link. Consumers must accept word_valid on every pulse; the minimum spacing is WORD_W cycles.

Test Plan:
- Clean short frame: TS=0x2AAAAAAA (30 bits), then 3 words 0x1234, 0xBEEF, 0x0001. Expect ts_valid with ts_out=0x2AAAAAAA; word_valid x3 with idx 0,1,2; frame_done with word_count=3; no errors.
- Full bank plus wrap: 1 TS, then 250 words of value=index. Expect bank_done on idx 199, idx wrap to 0 at word 200 (value 200), frame_done with word_count=250.
- Gapped strobes: rx_valid low 1-3 random cycles between bits in both fields. Expect outputs identical to the clean run.
- Short timestamp: rx_sel rises after 20 TS bits. Expect err_ts=1, no ts_valid, following words still received with idx starting at 0.
- Partial word: frame ends after 2 words plus 7 bits. Expect 2 word_valid, err_partial=1, word_count=2.
- Reset mid-word: assert reset after 10 data bits. Expect all outputs 0, busy=0. A clean frame afterwards must decode correctly.
